// File: rtl/sram_pkg.sv
// Shared definitions for the async SRAM port front-ends feeding the 4-way port mux.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WAIT_CNT_W  = 4;

endpackage

// File: rtl/sram_async_port_ctrl.sv
// Clocked req/ready front-end generating timed async SRAM strobes for one mux side.
// Optional multi-beat bursts are compiled in with `define SRAM_PORT_BURST_EN.
module sram_async_port_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int WAIT_CYC = 2
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iGRANT,
    input  logic              iREQ,
    output logic              oREADY,
    input  logic              iWR,
    input  logic [ADDR_W-1:0] iADDR,
    input  logic [DATA_W-1:0] iWDATA,
    input  logic [7:0]        iLEN,
    output logic [DATA_W-1:0] oRDATA,
    output logic              oRVALID,
    output logic              oERR,
    output logic [ADDR_W-1:0] oAS_ADDR,
    output logic [DATA_W-1:0] oAS_DATA,
    output logic              oAS_WE_N,
    output logic              oAS_OE_N,
    input  logic [DATA_W-1:0] iAS_DATA
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYC - 1);
    localparam logic [ADDR_W-1:0]     ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic                    isWr_r;
    logic [WAIT_CNT_W-1:0]   waitCnt_r;

`ifdef SRAM_PORT_BURST_EN
    logic [7:0]              beatsLeft_r;
`else
    logic                    unusedLen_s;
    assign unusedLen_s = ^iLEN;
`endif

    // Command FSM; every port output is a register so strobes are glitch-free.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r     <= IDLE;
            isWr_r      <= 1'b0;
            waitCnt_r   <= {WAIT_CNT_W{1'b0}};
            oREADY      <= 1'b0;
            oRVALID     <= 1'b0;
            oERR        <= 1'b0;
            oRDATA      <= {DATA_W{1'b0}};
            oAS_ADDR    <= {ADDR_W{1'b0}};
            oAS_DATA    <= {DATA_W{1'b0}};
            oAS_WE_N    <= 1'b1;
            oAS_OE_N    <= 1'b1;
`ifdef SRAM_PORT_BURST_EN
            beatsLeft_r <= 8'd0;
`endif
        end else begin
            oRVALID <= 1'b0;
            oERR    <= 1'b0;
            // Grant loss anywhere inside a transfer aborts it; the mux has already moved away.
            if ((state_r != IDLE) && !iGRANT) begin
                state_r  <= IDLE;
                oAS_WE_N <= 1'b1;
                oAS_OE_N <= 1'b1;
                oERR     <= 1'b1;
                oREADY   <= 1'b0;
`ifdef SRAM_PORT_BURST_EN
                beatsLeft_r <= 8'd0;
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        if (iREQ && oREADY) begin
                            isWr_r   <= iWR;
                            oAS_ADDR <= iADDR;
                            oAS_DATA <= iWDATA;
                            oREADY   <= 1'b0;
                            state_r  <= SETUP;
`ifdef SRAM_PORT_BURST_EN
                            beatsLeft_r <= iLEN;
`endif
                        end else begin
                            oREADY <= iGRANT;
                        end
                    end
                    SETUP: begin
                        waitCnt_r <= WAIT_LOAD;
                        state_r   <= ACCESS;
                        if (isWr_r) begin
                            oAS_WE_N <= 1'b0;
                        end else begin
                            oAS_OE_N <= 1'b0;
                        end
                    end
                    ACCESS: begin
                        if (waitCnt_r == {WAIT_CNT_W{1'b0}}) begin
                            oAS_WE_N <= 1'b1;
                            oAS_OE_N <= 1'b1;
                            if (isWr_r) begin
                                state_r <= HOLD;
`ifdef SRAM_PORT_BURST_EN
                                oREADY  <= (beatsLeft_r != 8'd0);
`endif
                            end else begin
                                oRDATA  <= iAS_DATA;
                                oRVALID <= 1'b1;
`ifdef SRAM_PORT_BURST_EN
                                if (beatsLeft_r != 8'd0) begin
                                    oAS_ADDR    <= oAS_ADDR + ADDR_ONE;
                                    beatsLeft_r <= beatsLeft_r - 8'd1;
                                    state_r     <= SETUP;
                                end else begin
                                    state_r <= IDLE;
                                    oREADY  <= iGRANT;
                                end
`else
                                state_r <= IDLE;
                                oREADY  <= iGRANT;
`endif
                            end
                        end else begin
                            waitCnt_r <= waitCnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    HOLD: begin
`ifdef SRAM_PORT_BURST_EN
                        // Remaining write beats stall here, strobes high, until the next word arrives.
                        if (beatsLeft_r != 8'd0) begin
                            if (iREQ && oREADY) begin
                                oAS_DATA    <= iWDATA;
                                oAS_ADDR    <= oAS_ADDR + ADDR_ONE;
                                beatsLeft_r <= beatsLeft_r - 8'd1;
                                oREADY      <= 1'b0;
                                state_r     <= SETUP;
                            end else begin
                                oREADY <= 1'b1;
                            end
                        end else begin
                            state_r <= IDLE;
                            oREADY  <= iGRANT;
                        end
`else
                        state_r <= IDLE;
                        oREADY  <= iGRANT;
`endif
                    end
                    default: begin
                        state_r  <= IDLE;
                        oAS_WE_N <= 1'b1;
                        oAS_OE_N <= 1'b1;
                        oREADY   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_async_port_ctrl.sv
// Scoreboard bench for sram_async_port_ctrl with a small behavioural SRAM behind the port.
module tb_sram_async_port_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int WAIT_CYC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iGRANT = 1'b1;
    logic          iREQ = 1'b0;
    logic          iWR = 1'b0;
    logic [AW-1:0] iADDR = '0;
    logic [DW-1:0] iWDATA = '0;
    logic [7:0]    iLEN = 8'd0;
    logic          oREADY, oRVALID, oERR, oAS_WE_N, oAS_OE_N;
    logic [DW-1:0] oRDATA, oAS_DATA, iAS_DATA;
    logic [AW-1:0] oAS_ADDR;

    typedef struct {
        bit          isErr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   nCmp = 0;
    int   nErr = 0;
    int   cycCnt = 0;
    logic grantAtEdge = 1'b1;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    sram_async_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WAIT_CYC)) dut (
        .iCLK(clk), .iRST_n(rst_n), .iGRANT(iGRANT), .iREQ(iREQ), .oREADY(oREADY),
        .iWR(iWR), .iADDR(iADDR), .iWDATA(iWDATA), .iLEN(iLEN), .oRDATA(oRDATA),
        .oRVALID(oRVALID), .oERR(oERR), .oAS_ADDR(oAS_ADDR), .oAS_DATA(oAS_DATA),
        .oAS_WE_N(oAS_WE_N), .oAS_OE_N(oAS_OE_N), .iAS_DATA(iAS_DATA)
    );

    // SRAM model indexed by the low address byte; preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'hFF] <= 16'hBEEF;
            mem[8'h00] <= 16'hA000;
            mem[8'h01] <= 16'hA001;
        end else if (!oAS_WE_N) begin
            mem[oAS_ADDR[7:0]] <= oAS_DATA;
        end
    end
    assign iAS_DATA = !oAS_OE_N ? mem[oAS_ADDR[7:0]] : 16'hDEAD;

    always @(posedge clk) begin
        cycCnt      <= cycCnt + 1;
        grantAtEdge <= iGRANT;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: strobe safety every cycle, and pops the scoreboard on each oRVALID/oERR.
    always @(negedge clk) begin
        if (rst_n) begin
            check("strobe_overlap", {31'd0, (!oAS_WE_N && !oAS_OE_N)}, 32'd0);
            if (!oAS_WE_N || !oAS_OE_N) check("strobe_without_grant", {31'd0, grantAtEdge}, 32'd1);
            if (oRVALID || oERR) begin
                if (expQ.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("FAIL unexpected_output: got oRVALID=%b oERR=%b, expected none", oRVALID, oERR);
                end else begin
                    monE = expQ.pop_front();
                    check("out_is_err", {31'd0, oERR}, {31'd0, monE.isErr});
                    check("out_rvalid", {31'd0, oRVALID}, {31'd0, !monE.isErr});
                    check("out_cycle", cycCnt, monE.cyc);
                    if (!monE.isErr) check("rdata", {16'd0, oRDATA}, {16'd0, monE.data});
                end
            end
        end
    end

    task automatic doCmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [7:0] len, output int acc);
        int n = 0;
        @(negedge clk);
        iREQ = 1'b1; iWR = wr; iADDR = addr; iWDATA = data; iLEN = len;
        while (!oREADY && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!oREADY) begin
            check("accept_timeout", 32'd0, 32'd1);
            iREQ = 1'b0;
            acc = -1;
        end else begin
            acc = cycCnt;
            @(posedge clk);
            #1 iREQ = 1'b0;
        end
    endtask

    // Cycles after accept: SETUP, ACCESS x2 (strobe low), then strobe high again.
    task automatic checkStrobes(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic expS;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            expS = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            check(wr ? "we_n_phase" : "oe_n_phase", {31'd0, wr ? oAS_WE_N : oAS_OE_N}, {31'd0, expS});
            check(wr ? "oe_n_idle" : "we_n_idle", {31'd0, wr ? oAS_OE_N : oAS_WE_N}, 32'd1);
            check("addr_stable", {14'd0, oAS_ADDR}, {14'd0, addr});
            if (wr) check("data_stable", {16'd0, oAS_DATA}, {16'd0, data});
        end
    endtask

    task automatic checkResetOutputs();
        check("rst_we_n", {31'd0, oAS_WE_N}, 32'd1);
        check("rst_oe_n", {31'd0, oAS_OE_N}, 32'd1);
        check("rst_ready", {31'd0, oREADY}, 32'd0);
        check("rst_rvalid", {31'd0, oRVALID}, 32'd0);
        check("rst_err", {31'd0, oERR}, 32'd0);
        check("rst_rdata", {16'd0, oRDATA}, 32'd0);
        check("rst_addr", {14'd0, oAS_ADDR}, 32'd0);
        check("rst_data", {16'd0, oAS_DATA}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        #23;
        checkResetOutputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, oREADY}, 32'd1);

        // Single write then read-back through the SRAM model.
        doCmd(1'b1, 18'h00010, 16'h1234, 8'd0, acc);
        checkStrobes(1'b1, 18'h00010, 16'h1234);
        @(negedge clk);
        check("ready_after_write", {31'd0, oREADY}, 32'd1);

        doCmd(1'b0, 18'h00010, 16'h0000, 8'd0, acc);
        expQ.push_back('{isErr: 1'b0, data: 16'h1234, cyc: acc + WAIT_CYC + 2});
        checkStrobes(1'b0, 18'h00010, 16'h0000);
        repeat (2) @(negedge clk);

        // No grant: request must not be accepted and strobes stay high.
        iGRANT = 1'b0;
        repeat (2) @(negedge clk);
        iREQ = 1'b1; iWR = 1'b0; iADDR = 18'h00010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nogrant_ready", {31'd0, oREADY}, 32'd0);
            check("nogrant_strobes", {30'd0, oAS_WE_N, oAS_OE_N}, 32'd3);
        end
        iREQ = 1'b0;
        iGRANT = 1'b1;
        repeat (2) @(negedge clk);

        // Grant dropped during ACCESS: abort with a single oERR, no read data.
        doCmd(1'b0, 18'h00010, 16'h0000, 8'd0, acc);
        expQ.push_back('{isErr: 1'b1, data: 16'h0000, cyc: acc + 3});
        @(negedge clk);
        @(negedge clk);
        check("abort_oe_low", {31'd0, oAS_OE_N}, 32'd0);
        iGRANT = 1'b0;
        @(negedge clk);
        check("abort_strobes_high", {30'd0, oAS_WE_N, oAS_OE_N}, 32'd3);
        @(negedge clk);
        iGRANT = 1'b1;
        repeat (3) @(negedge clk);

        // Top-of-range address.
        doCmd(1'b0, 18'h3FFFF, 16'h0000, 8'd0, acc);
        expQ.push_back('{isErr: 1'b0, data: 16'hBEEF, cyc: acc + WAIT_CYC + 2});
        repeat (6) @(negedge clk);

`ifdef SRAM_PORT_BURST_EN
        // Three-beat read wrapping 0x3FFFF -> 0x00000 -> 0x00001.
        doCmd(1'b0, 18'h3FFFF, 16'h0000, 8'd2, acc);
        expQ.push_back('{isErr: 1'b0, data: 16'hBEEF, cyc: acc + WAIT_CYC + 2});
        expQ.push_back('{isErr: 1'b0, data: 16'hA000, cyc: acc + 2 * WAIT_CYC + 3});
        expQ.push_back('{isErr: 1'b0, data: 16'hA001, cyc: acc + 3 * WAIT_CYC + 4});
        repeat (14) @(negedge clk);
`endif

        // Reset asserted while the write strobe is low.
        doCmd(1'b1, 18'h00020, 16'h5555, 8'd0, acc);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_we_low", {31'd0, oAS_WE_N}, 32'd0);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
